// File: rtl/mux_41_rr_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 mux datapath.
// Holds a grant per packet and forwards beats through one output register.
module mux_41_rr_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    in_valid,
  input  logic [3:0]    in_last,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]    in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [1:0]    sel,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic          ovld_q, ovld_d;
  logic [DW-1:0] odat_q, odat_d;
  logic          olst_q, olst_d;

  logic [3:0]    rot;
  logic [1:0]    off;
  logic          req_any;
  logic [1:0]    winner;
  logic          can_load;
  logic          accept;
  logic [DW-1:0] lane_sel;
  logic          last_sel;

  // Rotate requests so bit0 is the current top-priority requester.
  always_comb begin
    rot     = 4'(({in_valid, in_valid}) >> ptr_q);
    req_any = |in_valid;
    off     = 2'd0;
    if (rot[0]) begin
      off = 2'd0;
    end else if (rot[1]) begin
      off = 2'd1;
    end else if (rot[2]) begin
      off = 2'd2;
    end else if (rot[3]) begin
      off = 2'd3;
    end
    winner = ptr_q + off;
  end

  // Granted lane view and the accept condition.
  always_comb begin
    lane_sel = in_data[sel_q*DW +: DW];
    last_sel = in_last[sel_q];
    can_load = !ovld_q || out_ready;
    accept   = (state_q == GRANT) &&
               in_valid[sel_q] && can_load;
  end

  // State register; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arbitrate in IDLE, leave GRANT on the last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept && last_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the granted lane may see ready.
  always_comb begin
    in_ready = 4'b0000;
    busy     = (state_q == GRANT);
    if (state_q == GRANT) begin
      in_ready[sel_q] = can_load;
    end
  end

  // Grant, priority pointer and output register next values.
  always_comb begin
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    ovld_d = ovld_q;
    odat_d = odat_q;
    olst_d = olst_q;
    if (state_q == IDLE && req_any) begin
      sel_d = winner;
    end
    if (accept && last_sel) begin
      ptr_d = sel_q + 2'd1;
    end
    if (accept) begin
      ovld_d = 1'b1;
      odat_d = lane_sel;
      olst_d = last_sel;
    end else if (ovld_q && out_ready) begin
      ovld_d = 1'b0;
    end
  end

  // Datapath registers; a held beat is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= 2'd0;
      sel_q  <= 2'd0;
      ovld_q <= 1'b0;
      odat_q <= '0;
      olst_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      ovld_q <= ovld_d;
      odat_q <= odat_d;
      olst_q <= olst_d;
    end
  end

  assign out_valid = ovld_q;
  assign out_data  = odat_q;
  assign out_last  = olst_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_mux_41_rr_arbiter.sv
// Bench for mux_41_rr_arbiter: cycle table plus
// lane-queue scoreboard for multi-cycle sequences.
module tb_mux_41_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  sel;
  logic        busy;

  mux_41_rr_arbiter #(.DW(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .sel(sel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic [1:0]  e_sel;
    logic        e_busy;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int checks   = 0;
  int failures = 0;

  vec_t       tbl[12];
  beat_t      lane_q[4][$];
  beat_t      exp_q[$];
  logic [1:0] exp_sel[$];
  bit         sel_chk;
  bit         gap[4];
  bit         acc[4];
  bit         rdy;
  bit         busy_prev;

  function automatic vec_t mk(
    input logic [3:0] v, input logic [3:0] l,
    input logic [31:0] d, input logic [3:0] er,
    input logic eov, input logic [7:0] eod,
    input logic eol, input logic [1:0] es,
    input logic eb);
    vec_t r;
    r.v = v; r.l = l; r.d = d;
    r.e_rdy = er; r.e_ov = eov; r.e_od = eod;
    r.e_ol = eol; r.e_sel = es; r.e_busy = eb;
    return r;
  endfunction

  function automatic beat_t bt(input logic [7:0] d,
                               input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    return b;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (lane_q[i].size() > 0) begin
        in_valid[i]       = !gap[i];
        in_data[i*8 +: 8] = lane_q[i][0].d;
        in_last[i]        = lane_q[i][0].l;
      end else begin
        in_valid[i]       = 1'b0;
        in_data[i*8 +: 8] = 8'h00;
        in_last[i]        = 1'b0;
      end
    end
    out_ready = rdy;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) begin
      lane_q[i].delete();
      gap[i] = 1'b0;
      acc[i] = 1'b0;
    end
    exp_q.delete();
    exp_sel.delete();
    busy_prev = 1'b0;
    sel_chk   = 1'b0;
    rdy       = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sb();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle: drive after the edge, sample at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        void'(lane_q[i].pop_front());
        acc[i] = 1'b0;
      end
    end
    drive();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got %0h expected none",
                 out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_last", out_last, e.l);
      end
    end
    if (busy && !busy_prev && sel_chk) begin
      if (exp_sel.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_extra: got sel %0d expected none",
                 sel);
      end else begin
        chk("grant_sel", sel, exp_sel.pop_front());
      end
    end
    busy_prev = busy;
    for (int i = 0; i < 4; i++) begin
      acc[i] = in_valid[i] && in_ready[i];
    end
  endtask

  task automatic run_done(input string name,
                          input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_sel_left"}, exp_sel.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_sb();
    drive();

    //        v      l      d             rdy   ov od     ol s  b
    tbl[0]  = mk(4'h2, 4'h0, 32'h0000_1100, 4'h0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(4'h2, 4'h0, 32'h0000_1100, 4'h2, 0, 8'h00, 0, 1, 1);
    tbl[2]  = mk(4'h2, 4'h0, 32'h0000_2200, 4'h2, 1, 8'h11, 0, 1, 1);
    tbl[3]  = mk(4'h2, 4'h2, 32'h0000_3300, 4'h2, 1, 8'h22, 0, 1, 1);
    tbl[4]  = mk(4'h0, 4'h0, 32'h0000_0000, 4'h0, 1, 8'h33, 1, 1, 0);
    tbl[5]  = mk(4'h0, 4'h0, 32'h0000_0000, 4'h0, 0, 8'h33, 1, 1, 0);
    tbl[6]  = mk(4'h5, 4'h5, 32'h00C7_00A9, 4'h0, 0, 8'h33, 1, 1, 0);
    tbl[7]  = mk(4'h5, 4'h5, 32'h00C7_00A9, 4'h4, 0, 8'h33, 1, 2, 1);
    tbl[8]  = mk(4'h1, 4'h1, 32'h0000_00A9, 4'h0, 1, 8'hC7, 1, 2, 0);
    tbl[9]  = mk(4'h1, 4'h1, 32'h0000_00A9, 4'h1, 0, 8'hC7, 1, 0, 1);
    tbl[10] = mk(4'h0, 4'h0, 32'h0000_0000, 4'h0, 1, 8'hA9, 1, 0, 0);
    tbl[11] = mk(4'h0, 4'h0, 32'h0000_0000, 4'h0, 0, 8'hA9, 1, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      @(posedge clk);
      #1;
      in_valid  = tbl[r].v;
      in_last   = tbl[r].l;
      in_data   = tbl[r].d;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("t%0d_in_ready", r), in_ready, tbl[r].e_rdy);
      chk($sformatf("t%0d_out_valid", r), out_valid, tbl[r].e_ov);
      chk($sformatf("t%0d_out_data", r), out_data, tbl[r].e_od);
      chk($sformatf("t%0d_out_last", r), out_last, tbl[r].e_ol);
      chk($sformatf("t%0d_sel", r), sel, tbl[r].e_sel);
      chk($sformatf("t%0d_busy", r), busy, tbl[r].e_busy);
    end

    // Reset in the middle of a packet with a beat held.
    do_reset();
    lane_q[1].push_back(bt(8'h11, 1'b0));
    lane_q[1].push_back(bt(8'h22, 1'b0));
    lane_q[1].push_back(bt(8'h33, 1'b1));
    exp_q.push_back(bt(8'h11, 1'b0));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 10) begin
        step();
        n++;
      end
    end
    chk("mid_pre_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_sel", sel, 0);
    chk("mid_busy", busy, 0);
    clear_sb();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_in_ready", in_ready, 0);
    chk("mid_idle_out_valid", out_valid, 0);

    // Round robin over four single-beat packets.
    do_reset();
    sel_chk = 1'b1;
    lane_q[0].push_back(bt(8'hA0, 1'b1));
    lane_q[0].push_back(bt(8'hA1, 1'b1));
    lane_q[1].push_back(bt(8'hB0, 1'b1));
    lane_q[2].push_back(bt(8'hC0, 1'b1));
    lane_q[3].push_back(bt(8'hD0, 1'b1));
    exp_q.push_back(bt(8'hA0, 1'b1));
    exp_q.push_back(bt(8'hB0, 1'b1));
    exp_q.push_back(bt(8'hC0, 1'b1));
    exp_q.push_back(bt(8'hD0, 1'b1));
    exp_q.push_back(bt(8'hA1, 1'b1));
    exp_sel.push_back(2'd0);
    exp_sel.push_back(2'd1);
    exp_sel.push_back(2'd2);
    exp_sel.push_back(2'd3);
    exp_sel.push_back(2'd0);
    run_done("rr", 60);

    // Backpressure on the second beat of a b packet.
    do_reset();
    sel_chk = 1'b1;
    exp_sel.push_back(2'd1);
    lane_q[1].push_back(bt(8'h11, 1'b0));
    lane_q[1].push_back(bt(8'h22, 1'b1));
    exp_q.push_back(bt(8'h11, 1'b0));
    exp_q.push_back(bt(8'h22, 1'b1));
    step();
    step();
    chk("bp_grant_rdy", in_ready, 4'b0010);
    rdy = 1'b0;
    repeat (3) begin
      step();
      chk("bp_in_ready", in_ready, 4'b0000);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h11);
    end
    rdy = 1'b1;
    step();
    chk("bp_resume_rdy", in_ready, 4'b0010);
    run_done("bp", 20);

    // Pointer wrap from 3 to 0, skipping idle d.
    do_reset();
    sel_chk = 1'b1;
    lane_q[2].push_back(bt(8'hC5, 1'b1));
    exp_q.push_back(bt(8'hC5, 1'b1));
    exp_sel.push_back(2'd2);
    run_done("wrap_pre", 20);
    lane_q[0].push_back(bt(8'hA5, 1'b1));
    lane_q[2].push_back(bt(8'hC6, 1'b1));
    exp_q.push_back(bt(8'hA5, 1'b1));
    exp_q.push_back(bt(8'hC6, 1'b1));
    exp_sel.push_back(2'd0);
    exp_sel.push_back(2'd2);
    run_done("wrap", 30);

    // Granted c stalls mid-packet while d waits.
    do_reset();
    sel_chk = 1'b1;
    lane_q[2].push_back(bt(8'hC1, 1'b0));
    lane_q[2].push_back(bt(8'hC2, 1'b0));
    lane_q[2].push_back(bt(8'hC3, 1'b1));
    lane_q[3].push_back(bt(8'hD1, 1'b1));
    exp_q.push_back(bt(8'hC1, 1'b0));
    exp_q.push_back(bt(8'hC2, 1'b0));
    exp_q.push_back(bt(8'hC3, 1'b1));
    exp_q.push_back(bt(8'hD1, 1'b1));
    exp_sel.push_back(2'd2);
    exp_sel.push_back(2'd3);
    step();
    step();
    gap[2] = 1'b1;
    repeat (2) begin
      step();
      chk("gap_sel", sel, 2);
      chk("gap_in_ready", in_ready, 4'b0100);
      chk("gap_busy", busy, 1);
    end
    gap[2] = 1'b0;
    run_done("gap", 40);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
